// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared codes and helpers for the memory access unit
// Purpose: request size codes, RAM mode codes, FSM state encoding and
//          small size/alignment helper functions.
package mem_access_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_ILL  = 2'b11;

   localparam logic [1:0] MODE_BYTE = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ISSUE   = 2'b01,
      ST_CAPTURE = 2'b10,
      ST_RESP    = 2'b11
   } state_t;

   // Number of bytes touched by an access; 0 for the illegal size code.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SIZE_BYTE: n = 3'd1;
         SIZE_HALF: n = 3'd2;
         SIZE_WORD: n = 3'd4;
         default:   n = 3'd0;
      endcase
      return n;
   endfunction

   // Half not on an even address, or word not on a 4-byte boundary.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic m;
      case (size)
         SIZE_HALF: m = offset[0];
         SIZE_WORD: m = (offset != 2'b00);
         default:   m = 1'b0;
      endcase
      return m;
   endfunction

   // True when the access crosses into the next 32-bit word.
   function automatic logic spans_words(input logic [1:0] size, input logic [1:0] offset);
      return (({1'b0, offset} + size_bytes(size)) > 3'd4);
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - load byte selection and sign/zero extension
// Purpose: picks the addressed bytes out of the two-word assembly register
//          and extends them to 32 bits (little-endian).
// Ports:
//   asm_data    in  64  {word1, word0} as read from the RAM
//   offset      in  2   byte offset of the access within word0
//   size        in  2   access size code
//   unsigned_ld in  1   1 = zero-extend, 0 = sign-extend
//   rdata       out 32  extended load result
module load_align_ext
   import mem_access_unit_pkg::*;
(
   input  logic [63:0] asm_data,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   always_comb begin
      shifted = 32'(asm_data >> {offset, 3'b000});
      rdata   = 32'd0;
      case (size)
         SIZE_BYTE: rdata = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
         SIZE_HALF: rdata = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
         SIZE_WORD: rdata = shifted;
         default:   rdata = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store bridge between CPU and byte-addressable data RAM
// Purpose: accepts one load/store at a time, drives registered RAM beats,
//          splits word-crossing loads and misaligned stores, returns
//          extended load data and an error flag.
// Ports:
//   clk, clr                  clock, async active-high reset
//   req/we/size/unsigned_ld/addr/wdata   request (accepted when ready=1)
//   ready                     idle, able to accept
//   resp_valid/rdata/resp_err one-cycle completion with data and error
//   ram_addr/ram_din/ram_mode/ram_str/ram_sel/ram_ld   RAM controls (registered)
//   ram_dout                  RAM read data, valid the cycle after select
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_WIDTH       = 5,
   parameter bit ALLOW_MISALIGNED = 1'b1
)
(
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  req,
   input  logic                  we,
   input  logic [1:0]            size,
   input  logic                  unsigned_ld,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   output logic                  ready,
   output logic                  resp_valid,
   output logic [31:0]           rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   output logic [1:0]            ram_mode,
   output logic                  ram_str,
   output logic                  ram_sel,
   output logic                  ram_ld,
   input  logic [31:0]           ram_dout
);

   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

   state_t                  state_q, state_d;
   logic                    we_q, uns_q, err_q;
   logic [1:0]              size_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic [1:0]              beat_q, beat_d;
   logic [63:0]             asm_q;
   logic [31:0]             rdata_q;

   // Request validation on the live inputs (used only in IDLE).
   logic [32:0]             last_byte;
   logic                    out_of_range, req_err;

   // Transaction fields: live inputs while accepting, latched copies after.
   logic                    idle;
   logic                    t_we;
   logic [1:0]              t_size;
   logic [ADDR_WIDTH-1:0]   t_addr;
   logic [31:0]             t_wdata;
   logic                    t_mis;

   logic [2:0]              store_beats;
   logic                    load_spans;

   logic [ADDR_WIDTH-1:0]   ram_addr_d;
   logic [31:0]             ram_din_d;
   logic [1:0]              ram_mode_d;

   logic [31:0]             align_rdata, resp_rdata;

   assign ram_ld = 1'b1;

   assign last_byte    = {1'b0, addr} + 33'(size_bytes(size)) - 33'd1;
   assign out_of_range = |last_byte[32:ADDR_WIDTH];
   assign req_err      = (size == SIZE_ILL) || out_of_range ||
                         (is_misaligned(size, addr[1:0]) && !ALLOW_MISALIGNED);

   assign idle    = (state_q == ST_IDLE);
   assign t_we    = idle ? we : we_q;
   assign t_size  = idle ? size : size_q;
   assign t_addr  = idle ? addr[ADDR_WIDTH-1:0] : addr_q;
   assign t_wdata = idle ? wdata : wdata_q;
   assign t_mis   = is_misaligned(t_size, t_addr[1:0]);

   assign store_beats = is_misaligned(size_q, addr_q[1:0]) ? size_bytes(size_q) : 3'd1;
   assign load_spans  = spans_words(size_q, addr_q[1:0]);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               beat_d  = 2'd0;
               state_d = req_err ? ST_RESP : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!we_q) begin
               state_d = ST_CAPTURE;
            end else if (({1'b0, beat_q} + 3'd1) < store_beats) begin
               state_d = ST_ISSUE;
               beat_d  = beat_q + 2'd1;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_CAPTURE: begin
            if (load_spans && (beat_q == 2'd0)) begin
               state_d = ST_ISSUE;
               beat_d  = 2'd1;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // RAM beat contents for the beat about to be issued (index beat_d).
   // Loads always read whole aligned words; misaligned stores go byte by byte.
   always_comb begin
      ram_addr_d = t_addr;
      ram_din_d  = 32'd0;
      ram_mode_d = MODE_WORD;
      if (!t_we) begin
         ram_addr_d = (t_addr & WORD_MASK) + ADDR_WIDTH'({beat_d, 2'b00});
         ram_mode_d = MODE_WORD;
      end else if (t_mis) begin
         ram_addr_d = t_addr + ADDR_WIDTH'(beat_d);
         ram_din_d  = (t_wdata >> {beat_d, 3'b000}) & 32'h0000_00FF;
         ram_mode_d = MODE_BYTE;
      end else begin
         ram_addr_d = t_addr;
         ram_din_d  = t_wdata;
         ram_mode_d = t_size;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         uns_q    <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= SIZE_BYTE;
         addr_q   <= '0;
         wdata_q  <= 32'd0;
         beat_q   <= 2'd0;
         asm_q    <= 64'd0;
         rdata_q  <= 32'd0;
         ram_addr <= '0;
         ram_din  <= 32'd0;
         ram_mode <= MODE_WORD;
         ram_str  <= 1'b0;
         ram_sel  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (idle && req) begin
            we_q    <= we;
            uns_q   <= unsigned_ld;
            size_q  <= size;
            addr_q  <= addr[ADDR_WIDTH-1:0];
            wdata_q <= wdata;
            err_q   <= req_err;
            asm_q   <= 64'd0;
         end
         if (state_q == ST_CAPTURE) begin
            if (beat_q == 2'd0) asm_q[31:0]  <= ram_dout;
            else                asm_q[63:32] <= ram_dout;
         end
         if (state_q == ST_RESP) rdata_q <= resp_rdata;
         ram_sel <= (state_d == ST_ISSUE);
         ram_str <= (state_d == ST_ISSUE) && t_we;
         if (state_d == ST_ISSUE) begin
            ram_addr <= ram_addr_d;
            ram_din  <= ram_din_d;
            ram_mode <= ram_mode_d;
         end
      end
   end

   load_align_ext u_load_align_ext (
      .asm_data    (asm_q),
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .unsigned_ld (uns_q),
      .rdata       (align_rdata)
   );

   // Stores and rejected requests return zero data.
   assign resp_rdata = (err_q || we_q) ? 32'd0 : align_rdata;

   assign ready      = idle;
   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = (state_q == ST_RESP) && err_q;
   assign rdata      = (state_q == ST_RESP) ? resp_rdata : rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          clr = 1'b1;
   logic          req = 1'b0, we = 1'b0, unsigned_ld = 1'b0;
   logic [1:0]    size = 2'b00;
   logic [31:0]   addr = 32'd0, wdata = 32'd0;
   logic          ready, resp_valid, resp_err;
   logic [31:0]   rdata;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic [1:0]    ram_mode;
   logic          ram_str, ram_sel, ram_ld;
   logic [31:0]   ram_dout = 32'd0;

   logic          req2 = 1'b0, we2 = 1'b0;
   logic [1:0]    size2 = 2'b00;
   logic [31:0]   addr2 = 32'd0;
   logic          ready2, resp_valid2, resp_err2;
   logic [31:0]   rdata2;
   logic [AW-1:0] ram_addr2;
   logic [31:0]   ram_din2;
   logic [1:0]    ram_mode2;
   logic          ram_str2, ram_sel2, ram_ld2;
   logic [31:0]   ram_dout2 = 32'd0;

   int            checks = 0;
   int            errors = 0;

   logic [7:0]    mem [0:31];
   int            ra;

   int            nbeats;
   logic [31:0]   b_addr [0:7];
   logic [31:0]   b_mode [0:7];
   logic [31:0]   b_din  [0:7];
   logic [31:0]   got_rdata;
   logic          got_err;
   int            got_lat;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b1)) u_dut (
      .clk(clk), .clr(clr), .req(req), .we(we), .size(size),
      .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
      .ready(ready), .resp_valid(resp_valid), .rdata(rdata), .resp_err(resp_err),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_mode(ram_mode),
      .ram_str(ram_str), .ram_sel(ram_sel), .ram_ld(ram_ld), .ram_dout(ram_dout)
   );

   mem_access_unit #(.ADDR_WIDTH(AW), .ALLOW_MISALIGNED(1'b0)) u_dut_strict (
      .clk(clk), .clr(clr), .req(req2), .we(we2), .size(size2),
      .unsigned_ld(1'b0), .addr(addr2), .wdata(32'd0),
      .ready(ready2), .resp_valid(resp_valid2), .rdata(rdata2), .resp_err(resp_err2),
      .ram_addr(ram_addr2), .ram_din(ram_din2), .ram_mode(ram_mode2),
      .ram_str(ram_str2), .ram_sel(ram_sel2), .ram_ld(ram_ld2), .ram_dout(ram_dout2)
   );

   // Byte-addressable little-endian RAM, read data one cycle after select.
   always @(posedge clk) begin
      if (ram_sel) begin
         ra = int'(ram_addr);
         if (ram_str) begin
            mem[ra] <= ram_din[7:0];
            if (ram_mode != 2'b00) mem[(ra + 1) % 32] <= ram_din[15:8];
            if (ram_mode == 2'b10) begin
               mem[(ra + 2) % 32] <= ram_din[23:16];
               mem[(ra + 3) % 32] <= ram_din[31:24];
            end
         end else begin
            ram_dout <= {mem[(ra + 3) % 32], mem[(ra + 2) % 32], mem[(ra + 1) % 32], mem[ra]};
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
      bit done;
      @(negedge clk);
      we = w; size = sz; unsigned_ld = u; addr = a; wdata = d; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      nbeats = 0; got_lat = 0; got_rdata = 32'hXXXX_XXXX; got_err = 1'bx;
      done = 1'b0;
      for (int n = 1; n <= 20 && !done; n++) begin
         @(negedge clk);
         if (ram_sel) begin
            if (nbeats < 8) begin
               b_addr[nbeats] = 32'(ram_addr);
               b_mode[nbeats] = 32'(ram_mode);
               b_din[nbeats]  = ram_din;
            end
            nbeats++;
         end
         if (resp_valid) begin
            got_rdata = rdata; got_err = resp_err; got_lat = n; done = 1'b1;
         end
      end
      if (!done) check("resp_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_strict(input logic w, input logic [1:0] sz, input logic [31:0] a);
      bit done;
      @(negedge clk);
      we2 = w; size2 = sz; addr2 = a; req2 = 1'b1;
      @(posedge clk);
      #1 req2 = 1'b0;
      done = 1'b0; got_err = 1'bx;
      for (int n = 1; n <= 20 && !done; n++) begin
         @(negedge clk);
         if (resp_valid2) begin got_err = resp_err2; done = 1'b1; end
      end
      if (!done) check("strict_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int rv_seen;
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;

      // Reset state while clr is held
      #12;
      check("rst_ready",      32'(ready),      32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err",   32'(resp_err),   32'd0);
      check("rst_rdata",      rdata,           32'd0);
      check("rst_ram_sel",    32'(ram_sel),    32'd0);
      check("rst_ram_str",    32'(ram_str),    32'd0);
      check("rst_ram_addr",   32'(ram_addr),   32'd0);
      check("rst_ram_din",    ram_din,         32'd0);
      check("rst_ram_mode",   32'(ram_mode),   32'd2);
      check("rst_ram_ld",     32'(ram_ld),     32'd1);
      @(negedge clk);
      clr = 1'b0;

      // SW 0x8899AABB @0x04
      run_op(1'b1, 2'b10, 1'b0, 32'h04, 32'h8899AABB);
      check("sw4_lat",   32'(got_lat), 32'd2);
      check("sw4_err",   32'(got_err), 32'd0);
      check("sw4_beats", 32'(nbeats),  32'd1);
      check("sw4_addr",  b_addr[0],    32'h04);
      check("sw4_mode",  b_mode[0],    32'd2);
      check("sw4_din",   b_din[0],     32'h8899AABB);

      // LB 0x05 signed / unsigned
      run_op(1'b0, 2'b00, 1'b0, 32'h05, 32'd0);
      check("lb5_data",  got_rdata,    32'hFFFFFFAA);
      check("lb5_lat",   32'(got_lat), 32'd3);
      check("lb5_addr",  b_addr[0],    32'h04);
      run_op(1'b0, 2'b00, 1'b1, 32'h05, 32'd0);
      check("lbu5_data", got_rdata,    32'h000000AA);

      // LH 0x06 signed, LHU 0x04
      run_op(1'b0, 2'b01, 1'b0, 32'h06, 32'd0);
      check("lh6_data",  got_rdata,    32'hFFFF8899);
      check("lh6_beats", 32'(nbeats),  32'd1);
      check("lh6_mode",  b_mode[0],    32'd2);
      run_op(1'b0, 2'b01, 1'b1, 32'h04, 32'd0);
      check("lhu4_data", got_rdata,    32'h0000AABB);
      check("lhu4_beats",32'(nbeats),  32'd1);
      check("lhu4_mode", b_mode[0],    32'd2);

      // SW 0x11223344 @0x08, then word-crossing LW 0x06
      run_op(1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344);
      check("sw8_err",   32'(got_err), 32'd0);
      run_op(1'b0, 2'b10, 1'b0, 32'h06, 32'd0);
      check("lw6_data",  got_rdata,    32'h33448899);
      check("lw6_lat",   32'(got_lat), 32'd5);
      check("lw6_beats", 32'(nbeats),  32'd2);
      check("lw6_addr0", b_addr[0],    32'h04);
      check("lw6_addr1", b_addr[1],    32'h08);
      @(negedge clk);
      check("lw6_hold",  rdata,        32'h33448899);

      // Misaligned SW 0xDEADBEEF @0x03 -> four byte beats
      run_op(1'b1, 2'b10, 1'b0, 32'h03, 32'hDEADBEEF);
      check("sw3_lat",   32'(got_lat), 32'd5);
      check("sw3_beats", 32'(nbeats),  32'd4);
      check("sw3_addr0", b_addr[0],    32'h03);
      check("sw3_addr3", b_addr[3],    32'h06);
      check("sw3_mode1", b_mode[1],    32'd0);
      check("sw3_din0",  b_din[0],     32'h000000EF);
      check("sw3_din3",  b_din[3],     32'h000000DE);
      run_op(1'b0, 2'b10, 1'b0, 32'h00, 32'd0);
      check("lw0_data",  got_rdata,    32'hEF000000);
      run_op(1'b0, 2'b10, 1'b0, 32'h04, 32'd0);
      check("lw4_data",  got_rdata,    32'h88DEADBE);

      // Boundary byte at the top of the address space
      run_op(1'b1, 2'b00, 1'b0, 32'h1F, 32'h0000005A);
      check("sb1f_err",  32'(got_err), 32'd0);
      run_op(1'b0, 2'b00, 1'b1, 32'h1F, 32'd0);
      check("lbu1f_data",got_rdata,    32'h0000005A);
      check("lbu1f_err", 32'(got_err), 32'd0);

      // Error cases
      run_op(1'b0, 2'b10, 1'b0, 32'h1E, 32'd0);
      check("lw1e_err",  32'(got_err), 32'd1);
      check("lw1e_data", got_rdata,    32'd0);
      check("lw1e_sel",  32'(nbeats),  32'd0);
      check("lw1e_lat",  32'(got_lat), 32'd1);
      run_op(1'b0, 2'b11, 1'b0, 32'h00, 32'd0);
      check("sz11_err",  32'(got_err), 32'd1);
      check("sz11_sel",  32'(nbeats),  32'd0);
      run_strict(1'b0, 2'b01, 32'h01);
      check("strict_lh1_err", 32'(got_err), 32'd1);
      run_strict(1'b0, 2'b01, 32'h00);
      check("strict_lh0_err", 32'(got_err), 32'd0);

      // Reset during the second beat of a word-crossing load
      @(negedge clk);
      we = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h06; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("mid_sel",   32'(ram_sel),  32'd1);
      check("mid_addr",  32'(ram_addr), 32'h08);
      clr = 1'b1;
      #1;
      check("clr_ready",      32'(ready),      32'd1);
      check("clr_ram_sel",    32'(ram_sel),    32'd0);
      check("clr_resp_valid", 32'(resp_valid), 32'd0);
      check("clr_ram_mode",   32'(ram_mode),   32'd2);
      check("clr_ram_addr",   32'(ram_addr),   32'd0);
      @(negedge clk);
      clr = 1'b0;
      rv_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_valid) rv_seen++;
      end
      check("clr_no_resp", 32'(rv_seen), 32'd0);
      run_op(1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
      check("post_clr_data", got_rdata,    32'h11223344);
      check("post_clr_lat",  32'(got_lat), 32'd3);
      check("post_clr_err",  32'(got_err), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
